// File: rtl/rv32_register_file.sv
// RV32I integer register file: two combinational read ports, one clocked write port.
// x0 is hardwired to zero; an asynchronous active-low reset clears the whole array.
module rv32_register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rs1,
  output logic [DATA_WIDTH-1:0] rd1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic [DATA_WIDTH-1:0] rd2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] rd_wd,
  input  logic                  rd_we
);

  localparam int NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  wr_en;

  // Writes to x0 are dropped here so the storage for index 0 never leaves zero.
  assign wr_en = rd_we && (rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[rd] <= rd_wd;
    end
  end

  // No write bypass: a same-cycle write becomes visible only after the edge.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rst_n && (rs1 != '0)) rd1 = regs[rs1];
    if (rst_n && (rs2 != '0)) rd2 = regs[rs2];
  end

endmodule

// File: tb/tb_rv32_register_file.sv
// Directed bench for rv32_register_file: reset, write/read, x0, enable, read-during-write,
// full sweep and asynchronous reset between clock edges.
module tb_rv32_register_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1;
  logic [31:0] rd1;
  logic [4:0]  rs2;
  logic [31:0] rd2;
  logic [4:0]  rd;
  logic [31:0] rd_wd;
  logic        rd_we;

  int checks;
  int errors;

  rv32_register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rs1   (rs1),
    .rd1   (rd1),
    .rs2   (rs2),
    .rd2   (rd2),
    .rd    (rd),
    .rd_wd (rd_wd),
    .rd_we (rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    rs1    = '0;
    rs2    = '0;
    rd     = 5'd5;
    rd_wd  = 32'hCAFEF00D;
    rd_we  = 1'b1;

    // Reset held: every index reads zero, and writes across an edge are ignored.
    #2;
    for (int k = 0; k < 32; k++) begin
      rs1 = 5'(k);
      rs2 = 5'(31 - k);
      #1;
      check("reset_rd1", rd1, 32'h0);
      check("reset_rd2", rd2, 32'h0);
    end
    tick();
    rs1 = 5'd5;
    #1;
    check("reset_write_ignored", rd1, 32'h0);
    rd_we = 1'b0;
    rst_n = 1'b1;
    #1;
    check("after_release_rd1", rd1, 32'h0);

    // Basic write/read.
    tick();
    rd = 5'd5; rd_wd = 32'hDEADBEEF; rd_we = 1'b1;
    tick();
    rd_we = 1'b0;
    rs1 = 5'd5; rs2 = 5'd5;
    #1;
    check("basic_rd1", rd1, 32'hDEADBEEF);
    check("basic_rd2", rd2, 32'hDEADBEEF);
    rs1 = 5'd4; rs2 = 5'd6;
    #1;
    check("basic_other_rd1", rd1, 32'h0);
    check("basic_other_rd2", rd2, 32'h0);

    // x0 protection.
    rd = 5'd0; rd_wd = 32'hFFFFFFFF; rd_we = 1'b1;
    tick();
    rd_we = 1'b0;
    rs1 = 5'd0;
    #1;
    check("x0_rd1", rd1, 32'h0);

    // Write disable across several edges.
    rd = 5'd7; rd_wd = 32'h12345678; rd_we = 1'b0;
    tick(); tick(); tick();
    rs2 = 5'd7;
    #1;
    check("we0_rd2", rd2, 32'h0);

    // Read-during-write: old value before the edge, new value after.
    rd = 5'd3; rd_wd = 32'h11; rd_we = 1'b1;
    tick();
    rd_wd = 32'h22;
    rs1 = 5'd3;
    #1;
    check("rdw_before", rd1, 32'h11);
    tick();
    rd_we = 1'b0;
    check("rdw_after", rd1, 32'h22);

    // Consecutive writes with rd_we held high: reg k = k * 0x01010101.
    rd_we = 1'b1;
    for (int k = 1; k < 32; k++) begin
      rd    = 5'(k);
      rd_wd = 32'(k) * 32'h01010101;
      tick();
    end
    rd_we = 1'b0;
    for (int k = 0; k < 32; k++) begin
      rs1 = 5'(k);
      rs2 = 5'(31 - k);
      #1;
      check("sweep_rd1", rd1, 32'(k) * 32'h01010101);
      check("sweep_rd2", rd2, 32'(31 - k) * 32'h01010101);
    end

    // Async reset between edges, with a write pending that must be discarded.
    tick();
    rd = 5'd9; rd_wd = 32'h99999999; rd_we = 1'b1;
    rs1 = 5'd31; rs2 = 5'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd1", rd1, 32'h0);
    check("async_rst_rd2", rd2, 32'h0);
    tick();
    rd_we = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      rs1 = 5'(k);
      #1;
      check("post_rst_sweep", rd1, 32'h0);
    end

    // Writes work again after reset; neighbours and x0 are unaffected.
    rd = 5'd31; rd_wd = 32'hA5A5A5A5; rd_we = 1'b1;
    tick();
    rd_we = 1'b0;
    rs1 = 5'd31; rs2 = 5'd0;
    #1;
    check("post_rst_write", rd1, 32'hA5A5A5A5);
    check("post_rst_x0", rd2, 32'h0);
    rs1 = 5'd30; rs2 = 5'd9;
    #1;
    check("post_rst_neighbour", rd1, 32'h0);
    check("post_rst_discarded", rd2, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
